// File: rtl/memory_stage.sv
// memory_stage: memory pipeline stage (IDLE/WAIT/FULL) with load alignment and decode bypass.
// Define MEM_STAGE_UNALIGNED_EN to merge LWL/LWR with the old rt value; otherwise they load as LW.
`ifndef I_MAX
`define I_WEX   0
`define I_MEM_R 1
`define I_MEM_W 2
`define I_LB    3
`define I_LBU   4
`define I_LH    5
`define I_LHU   6
`define I_LW    7
`define I_LWL   8
`define I_LWR   9
`define I_MAX   10
`endif

module memory_stage (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       inst_i,
    input  logic [`I_MAX-1:0] ctrl_i,
    input  logic [31:0]       result_i,
    input  logic [31:0]       eaddr_i,
    input  logic [31:0]       rdata2_i,
    input  logic [4:0]        waddr_i,
    output logic              ready_o,
    input  logic [31:0]       data_rdata,
    input  logic              data_data_ok,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic [4:0]        waddr_o,
    output logic [31:0]       wdata_o,
    output logic              we_o,
    output logic [4:0]        fwd_addr,
    output logic [31:0]       fwd_data,
    output logic              fwd_ok
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FULL} state_t;
    state_t            state_q, state_d;
    logic [31:0]       pc_q, inst_q, wdata_q, wdata_d, ld_data, ld_shr;
    logic [`I_MAX-1:0] ctrl_q;
    logic [4:0]        waddr_q, sh_r;
    logic [1:0]        off_q;
    logic [15:0]       ld_h;
    logic              accept, resp;
    logic              unused_ok;

    assign ready_o = state_q == S_IDLE || (state_q == S_FULL && ready_i);
    assign accept  = valid_i && ready_o;
    // A response is only meaningful while a request is outstanding; strays are dropped here.
    assign resp    = state_q == S_WAIT && data_data_ok;
    assign sh_r    = {off_q, 3'b000};
    assign ld_shr  = data_rdata >> sh_r;
    assign ld_h    = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];

`ifdef MEM_STAGE_UNALIGNED_EN
    logic [31:0] rdata2_q;
    logic [4:0]  sh_l;
    assign sh_l      = {~off_q, 3'b000};
    assign unused_ok = ^{eaddr_i[31:2], ctrl_q[`I_MEM_W], ctrl_q[`I_LW]};
`else
    assign unused_ok = ^{eaddr_i[31:2], rdata2_i, ctrl_q[`I_MEM_W], ctrl_q[`I_LW], ctrl_q[`I_LWL], ctrl_q[`I_LWR]};
`endif

    always_comb begin
        ld_data = ctrl_q[`I_LB]  ? {{24{ld_shr[7]}}, ld_shr[7:0]} :
                  ctrl_q[`I_LBU] ? {24'b0, ld_shr[7:0]} :
                  ctrl_q[`I_LH]  ? {{16{ld_h[15]}}, ld_h} :
                  ctrl_q[`I_LHU] ? {16'b0, ld_h} : data_rdata;
`ifdef MEM_STAGE_UNALIGNED_EN
        if (ctrl_q[`I_LWL]) ld_data = (data_rdata << sh_l) | (rdata2_q & ~(32'hFFFF_FFFF << sh_l));
        if (ctrl_q[`I_LWR]) ld_data = ld_shr | (rdata2_q & ~(32'hFFFF_FFFF >> sh_r));
`endif
    end

    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        if (state_q == S_FULL && ready_i) state_d = S_IDLE;
        if (resp) begin
            state_d = S_FULL;
            wdata_d = ctrl_q[`I_MEM_R] ? ld_data : wdata_q;
        end
        if (accept) begin
            state_d = (ctrl_i[`I_MEM_R] || ctrl_i[`I_MEM_W]) ? S_WAIT : S_FULL;
            wdata_d = result_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wdata_q <= '0;
            pc_q    <= '0;
            inst_q  <= '0;
            ctrl_q  <= '0;
            waddr_q <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            if (accept) begin
                pc_q    <= pc_i;
                inst_q  <= inst_i;
                ctrl_q  <= ctrl_i;
                waddr_q <= waddr_i;
                off_q   <= eaddr_i[1:0];
            end
        end
    end

`ifdef MEM_STAGE_UNALIGNED_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata2_q <= '0;
        else if (accept) rdata2_q <= rdata2_i;
    end
`endif

    assign valid_o  = state_q == S_FULL;
    assign pc_o     = pc_q;
    assign inst_o   = inst_q;
    assign waddr_o  = waddr_q;
    assign wdata_o  = wdata_q;
    assign we_o     = valid_o && ctrl_q[`I_WEX] && waddr_q != 5'd0;
    assign fwd_addr = state_q != S_IDLE ? waddr_q : 5'd0;
    assign fwd_data = wdata_q;
    assign fwd_ok   = valid_o && ctrl_q[`I_WEX];
endmodule
